// File: rtl/piso_tx_defs.sv
// Shared definitions for the serial bit link: FSM state encodings and line levels.
// The receive-side capture chain imports the same package.
package piso_tx_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: Tick is high on the last clock of each DIV-cycle bit period while En=1.
module bit_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic Cp,
  input  logic Rst,
  input  logic En,
  output logic Tick
);

  // DIV=1 still gets a 1-bit counter; it simply never leaves zero.
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign Tick = En && (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (!En || Tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge Cp) begin
    if (Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits LSB-first, stop bit.
// All outputs are registered from the next-state decode, so there are no input-to-output paths.
module piso_frame_tx
  import piso_tx_defs::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             Cp,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic             Ready,
  output logic             Q,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             q_q, q_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tick_c;
  logic             active_c;

  assign active_c = (state_q != IDLE);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .Cp   (Cp),
    .Rst  (Rst),
    .En   (active_c),
    .Tick (tick_c)
  );

  // Next-state and next-output decode; outputs follow the state being entered.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (Load) begin
          shreg_d = D;
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_c) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick_c) begin
          shreg_d = shreg_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(WIDTH - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick_c) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   q_d = LINE_START;
      DATA:    q_d = shreg_d[0];
      default: q_d = LINE_IDLE;
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Cp) begin
    if (Rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      q_q     <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      q_q     <= q_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign Ready = ready_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

  // The bit index may reach WIDTH on entry to STOP but never go beyond it.
  idx_in_range : assert property (@(posedge Cp) disable iff (Rst) idx_q <= IDX_W'(WIDTH));

endmodule
